control_acceso_param: RTL

Parametrised successor to the single-PIN gate access controller. It validates a BCD PIN of N_DIGITOS digits using an explicit entry strobe, and tracks failed attempts up to a configurable limit. It auto-closes the gate after a configurable timeout if no vehicle passes, and distinguishes PIN-lockout from tailgating-lockout. It sits between the gate keypad/sensor front-end and the gate motor/alarm drivers.

---
 rtl/control_acceso_param.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/control_acceso_param.sv
// Gate access controller: validates a BCD PIN strobed in by the keypad,
// counts failed attempts up to a lockout limit, auto-closes the gate after a
// timeout and separates PIN lockout (AI) from tailgating lockout (AB).
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   LV, CV         vehicle present at gate / vehicle passed through gate
//   BR             lockout release button (only honoured in BLOQUEO)
//   clave          BCD PIN, N_DIGITOS digits, sampled when clave_valida=1
//   clave_valida   one-cycle strobe marking a complete PIN entry
//   AC, CP         open / close gate pulses (one cycle)
//   AI, AB         wrong-PIN alarm / lockout-tailgating alarm (levels)
//   intentos       failed-attempt count, saturates at MAX_INTENTOS
//   estado         state code: 00 ESPERA, 01 INGRESO, 10 PASANDO, 11 BLOQUEO
module control_acceso_param #(
    parameter int unsigned                N_DIGITOS      = 4,
    parameter logic [4*N_DIGITOS-1:0]     CLAVE_CORRECTA = 16'h2468,
    parameter int unsigned                MAX_INTENTOS   = 3,
    parameter int unsigned                TIMEOUT_CICLOS = 1000,
    localparam int unsigned               W              = 4 * N_DIGITOS,
    localparam int unsigned               CW             = $clog2(MAX_INTENTOS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          LV,
    input  logic          CV,
    input  logic          BR,
    input  logic [W-1:0]  clave,
    input  logic          clave_valida,
    output logic          AC,
    output logic          CP,
    output logic          AI,
    output logic          AB,
    output logic [CW-1:0] intentos,
    output logic [1:0]    estado
);

    // Timer only needs to reach TIMEOUT_CICLOS-1.
    localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [1:0] {
        ESPERA  = 2'b00,
        INGRESO = 2'b01,
        PASANDO = 2'b10,
        BLOQUEO = 2'b11
    } estado_t;

    // Elaboration-time parameter range checks.
    if (N_DIGITOS == 0 || N_DIGITOS > 8) begin : g_bad_n_digitos
        $error("control_acceso_param: N_DIGITOS=%0d outside 1..8", N_DIGITOS);
    end
    if (MAX_INTENTOS == 0 || MAX_INTENTOS > 15) begin : g_bad_max_intentos
        $error("control_acceso_param: MAX_INTENTOS=%0d outside 1..15", MAX_INTENTOS);
    end

    estado_t       st, st_n;
    logic          ac_n, cp_n, ai_n, ab_n;
    logic [CW-1:0] intentos_n;
    logic [TW-1:0] timer, timer_n;
    logic          bcd_ok_c;
    logic          clave_ok_c;
    logic          ultimo_intento_c;

    // A PIN with any nibble above 9 never matches, even if the constant does.
    always_comb begin
        bcd_ok_c = 1'b1;
        for (int unsigned i = 0; i < N_DIGITOS; i++) begin
            if (clave[4*i +: 4] > 4'd9) begin
                bcd_ok_c = 1'b0;
            end
        end
    end

    assign clave_ok_c       = bcd_ok_c && (clave == CLAVE_CORRECTA);
    assign ultimo_intento_c = (32'(intentos) + 32'd1) >= MAX_INTENTOS;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= ESPERA;
            AC       <= 1'b0;
            CP       <= 1'b0;
            AI       <= 1'b0;
            AB       <= 1'b0;
            intentos <= '0;
            timer    <= '0;
        end else begin
            st       <= st_n;
            AC       <= ac_n;
            CP       <= cp_n;
            AI       <= ai_n;
            AB       <= ab_n;
            intentos <= intentos_n;
            timer    <= timer_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        st_n       = st;
        ac_n       = 1'b0;
        cp_n       = 1'b0;
        ai_n       = AI;
        ab_n       = AB;
        intentos_n = intentos;
        timer_n    = '0;

        case (st)
            ESPERA: begin
                if (LV && CV) begin
                    st_n = BLOQUEO;
                    ab_n = 1'b1;
                end else if (LV) begin
                    st_n = INGRESO;
                end
            end

            INGRESO: begin
                if (!LV) begin
                    st_n = ESPERA;
                end else if (clave_valida) begin
                    if (clave_ok_c) begin
                        st_n       = PASANDO;
                        ac_n       = 1'b1;
                        intentos_n = '0;
                    end else if (ultimo_intento_c) begin
                        st_n       = BLOQUEO;
                        ai_n       = 1'b1;
                        intentos_n = CW'(MAX_INTENTOS);
                    end else begin
                        intentos_n = intentos + CW'(1);
                    end
                end
            end

            PASANDO: begin
                if (TIMEOUT_CICLOS > 0) begin
                    timer_n = timer + TW'(1);
                end
                // Tailgating wins over a clean pass and over the timeout.
                if (CV && LV) begin
                    st_n = BLOQUEO;
                    ab_n = 1'b1;
                end else if (CV) begin
                    st_n = ESPERA;
                    cp_n = 1'b1;
                end else if (TIMEOUT_CICLOS > 0 && timer == T_LAST) begin
                    st_n = ESPERA;
                    cp_n = 1'b1;
                end
            end

            BLOQUEO: begin
                if (BR) begin
                    st_n       = ESPERA;
                    ai_n       = 1'b0;
                    ab_n       = 1'b0;
                    intentos_n = '0;
                end
            end

            default: begin
                st_n = ESPERA;
            end
        endcase
    end

    assign estado = st;

endmodule
